// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings and FSM state type.
package muldiv_seq_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed MULT/DIV sequencer: WIDTH-step shift-add multiply or
// restoring divide on magnitudes, sign fix-up, then HI/LO load enables.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_load,
  output logic             lo_load,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_t state, state_n;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sp, sr, is_div, zero_flag;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   accp;   // P (multiply) or R (divide)
  logic [WIDTH-1:0] accq;   // M (multiply) or Q (divide)

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // One adder serves both: P + |a| for MUL, shifted R - |b| for DIV.
  // For DIV, bit WIDTH+1 of the sum is the no-borrow flag (T >= 0).
  logic [WIDTH:0]   div_shift, add_x, add_y, p_sum;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;

  assign div_shift = {accp[WIDTH-1:0], accq[WIDTH-1]};

  always_comb begin
    add_x   = accp;
    add_y   = {1'b0, mag_a};
    add_cin = 1'b0;
    if (state == S_DIV) begin
      add_x   = div_shift;
      add_y   = ~{1'b0, mag_b};
      add_cin = 1'b1;
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
  assign p_sum   = accq[0] ? add_sum[WIDTH:0] : accp;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {accp[WIDTH-1:0], accq};
  assign prod_fix = sp ? -prod : prod;
  assign quo_fix  = sp ? -accq : accq;
  assign rem_fix  = sr ? -accp[WIDTH-1:0] : accp[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (start) begin
          if (op == OP_MULT)     state_n = S_MUL;
          else if (b == '0)      state_n = S_DONE;
          else                   state_n = S_DIV;
        end
      S_MUL, S_DIV:
        if (cnt == CNT_W'(1)) state_n = S_FIX;
      S_FIX:   state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_a     <= '0;
      mag_b     <= '0;
      sp        <= 1'b0;
      sr        <= 1'b0;
      is_div    <= 1'b0;
      zero_flag <= 1'b0;
      cnt       <= '0;
      accp      <= '0;
      accq      <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (start) begin
            mag_a     <= a_mag;
            mag_b     <= b_mag;
            sp        <= a[WIDTH-1] ^ b[WIDTH-1];
            sr        <= a[WIDTH-1];
            is_div    <= (op == OP_DIV);
            zero_flag <= (op == OP_DIV) && (b == '0);
            cnt       <= CNT_W'(WIDTH);
            accp      <= '0;
            accq      <= (op == OP_DIV) ? a_mag : b_mag;
          end
        S_MUL: begin
          accp <= {1'b0, p_sum[WIDTH:1]};
          accq <= {p_sum[0], accq[WIDTH-1:1]};
          cnt  <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          if (add_sum[WIDTH+1]) begin
            accp <= add_sum[WIDTH:0];
            accq <= {accq[WIDTH-2:0], 1'b1};
          end else begin
            accp <= div_shift;
            accq <= {accq[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          hi_out <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_out <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign div_zero = done && zero_flag;
  assign hi_load  = done && !zero_flag;
  assign lo_load  = done && !zero_flag;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: table vectors, a random model-checked
// batch, ignored/back-to-back starts and an asynchronous reset mid-operation.
module tb_muldiv_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, div_zero, hi_load, lo_load;
  logic [WIDTH-1:0] hi_out, lo_out;

  muldiv_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi_load(hi_load), .lo_load(lo_load), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; that cycle becomes cycle 0.
  // extra_at > 0 injects a stray DIV-by-zero start during that cycle.
  task automatic run_op(input vec_t v, input int extra_at, input string tag);
    vec_t e;
    int   cyc;
    int   busy_low;
    bit   seen;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    sb.push_back(v);
    cyc = 0; seen = 0; busy_low = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_at);
      if (cyc == extra_at) begin op = 1'b1; b = '0; end
      if (!busy) busy_low++;
      if (done) seen = 1;
    end
    e = sb.pop_front();
    check({tag, " busy_held"}, 64'(busy_low), 64'd0);
    if (!seen) begin
      check({tag, " done_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, " done_cycle"}, 64'(cyc), e.dz ? 64'd1 : 64'(WIDTH + 2));
      check({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
      check({tag, " loads"}, {62'd0, hi_load, lo_load}, e.dz ? 64'd0 : 64'd3);
      if (!e.dz) begin
        check({tag, " hi_out"}, 64'(hi_out), 64'(e.hi));
        check({tag, " lo_out"}, 64'(lo_out), 64'(e.lo));
      end
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, " after_done"}, {61'd0, busy, done, hi_load}, 64'd0);
  endtask

  function automatic vec_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
    vec_t   r;
    longint p;
    int     sx, sy;
    sx = x; sy = y;
    r.op = o; r.a = x; r.b = y; r.dz = 1'b0;
    if (o == 1'b0) begin
      p = longint'(sx) * longint'(sy);
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else begin
      r.lo = 32'(sx / sy);
      r.hi = 32'(sx % sy);
    end
    return r;
  endfunction

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0};
    tbl[1] = '{1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tbl[2] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
    tbl[3] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[4] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
    tbl[6] = '{1'b1, 32'd5,        32'd0,        32'h0,        32'h0,        1'b1};
    tbl[7] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    check("reset_ctrl", {59'd0, busy, done, div_zero, hi_load, lo_load}, 64'd0);
    check("reset_data", {hi_out, lo_out}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(tbl[i], 0, $sformatf("vec%0d", i));

    // Stray start at cycle 10 is ignored; next op starts at cycle 35.
    run_op('{1'b0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0}, 10, "ignore_start");
    run_op('{1'b1, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0}, 0, "back_to_back");

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        ro;
      ra = $urandom; rb = $urandom; ro = 1'($urandom_range(0, 1));
      if (i[0]) rb = rb >> $urandom_range(0, 30);
      if (rb == 0) rb = 32'd3;
      if (ro && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
      run_op(model(ro, ra, rb), 0, $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_reset_ctrl", {60'd0, busy, done, hi_load, lo_load}, 64'd0);
    check("mid_reset_data", {hi_out, lo_out}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 64'(busy), 64'd0);
    run_op('{1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0}, 0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative signed multiply/divide sequencer for the multicycle CPU's MULT/DIV instructions.
- Takes rs/rt operands on a start pulse and runs a WIDTH-step shift-add multiply or restoring divide.
- Raises busy so the main control unit holds in its wait state, then drives load enables and data for the external HI/LO registers.
- HI/LO are instances of the team's generic load-enabled register, outside this block.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse from the control unit; sampled only in IDLE.
- op  in  1  0 = MULT (signed), 1 = DIV (signed); sampled with start.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  high with done when DIV had b==0.
- hi_load  out  1  load enable for the HI register.
- lo_load  out  1  load enable for the LO register.
- hi_out  out  WIDTH  HI result data.
- lo_out  out  WIDTH  LO result data.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; accumulators, counter and sign flags cleared.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Timing is numbered by cycle; cycle 0 is the cycle with start=1 in IDLE.

IDLE, on start (latched at the edge ending cycle 0):
- Store |a| and |b| as unsigned WIDTH-bit magnitudes.
- Store sign flags: sp = a[msb]^b[msb] and sr = a[msb].
- Load counter = WIDTH.
- Next state is MUL for op=0, DIV for op=1 with b!=0, or DONE with the zero flag set for op=1 with b==0.

MUL, one step per cycle (cycles 1..WIDTH):
- Accumulator is {P[WIDTH:0], M[WIDTH-1:0]}, with P cleared and M = |b|.
- If M[0]=1, P += |a| (WIDTH+1 bits, no overflow loss).
- Then shift {P,M} right by 1.
- Decrement counter; at counter==1 go to FIX.

DIV, restoring, one step per cycle (cycles 1..WIDTH):
- Accumulator is {R[WIDTH:0], Q[WIDTH-1:0]}, with R cleared and Q = |a|.
- Shift {R,Q} left by 1, then compute T = R - |b|.
- If T is non-negative, R = T and Q[0] = 1.
- Same counter rule as MUL.

FIX (cycle WIDTH+1):
- MUL: if sp, negate the 2*WIDTH product {P[WIDTH-1:0], M}; HI = upper half, LO = lower half.
- DIV: LO = Q, negated if sp (truncation toward zero); HI = R, negated if sr (remainder takes the dividend's sign).
- Go to DONE.

DONE (cycle WIDTH+2, exactly one cycle):
- done=1.
- Normal completion: hi_load=lo_load=1.
- Divide by zero: hi_load=lo_load=0 and div_zero=1, so HI/LO keep their old values.
- Next state is IDLE.

Handshake and output rules:
- busy=1 in every non-IDLE state, including DONE: cycles 1..WIDTH+2 normally, cycle 1 only for divide by zero.
- start while busy is ignored, not queued; a start that arrives in the DONE cycle is also ignored.
- A new start is accepted in the first IDLE cycle after DONE.
- hi_out/lo_out are valid while hi_load is asserted and hold their value until the next accepted start.
- 0x80000000 / -1 yields LO=0x80000000, HI=0 (natural result of the magnitude algorithm; no trap).
- Magnitude of 0x80000000 is 0x80000000 unsigned; no special case needed.

Decomposition:
- Shared CPU definitions header: op encodings (OP_MULT=0, OP_DIV=1) and FSM state localparams for IDLE/MUL/DIV/FIX/DONE.
- No sub-module needed.
- FSM, counter and both accumulators live in one module; the add/subtract may share one WIDTH+1-bit adder.
- HI/LO storage stays external: two generic register instances in the top level, fed by hi_out/lo_out and hi_load/lo_load.

Test Plan:
- MULT a=7, b=6 -> busy cycles 1..34, done at cycle 34, hi_out=0x00000000, lo_out=0x0000002A, hi_load=lo_load=1 for exactly one cycle.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> hi_out=0x40000000, lo_out=0.
- DIV a=100, b=7 -> lo_out=14, hi_out=2; DIV a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; done at cycle 34.
- DIV a=5, b=0 -> done=div_zero=busy=1 at cycle 1, hi_load=lo_load=0, back to IDLE at cycle 2.
- MULT 3x3 with an extra start pulse (op=1) at cycle 10 -> ignored; result hi=0, lo=9 at cycle 34; back-to-back start at cycle 35 accepted.
- Reset asserted mid-MUL at cycle 12 -> busy, done and load enables drop to 0 immediately (asynchronously); after release, MULT 2x2 completes normally with lo_out=4.
